fib_seq_gen: RTL and testbench

//  Generates the Fibonacci sequence 0,1,1,2,3,5,8,13,... one term per handshake.
//  It is the producer counterpart of the combinational Fibonacci detector.

---
 rtl/fib_seq_gen.sv | 78 +++++++
 tb/tb_fib_seq_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator with a valid/ready output stream, launched by a start pulse.
// Optional build macro FIB_SEQ_GEN_BCD_EN caps the sequence at 9 (single BCD digits).
module fib_seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef FIB_SEQ_GEN_BCD_EN
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(9);
`else
  localparam logic [WIDTH:0] LIMIT = {1'b0, {WIDTH{1'b1}}};
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt;
  logic [WIDTH:0]   b, b_nxt;
  logic             accept;

  assign accept    = out_valid & out_ready;
  assign out_data  = a;
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
    end
  end

  // b only advances while it is <= LIMIT, so a+b stays within 2*LIMIT and fits WIDTH+1 bits.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    case (state)
      IDLE: begin
        if (start && !clear) begin
          state_nxt = RUN;
          a_nxt     = '0;
          b_nxt     = (WIDTH+1)'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = IDLE;
        end else if (accept) begin
          if (b > LIMIT) begin
            state_nxt = DONE;
          end else begin
            a_nxt = b[WIDTH-1:0];
            b_nxt = {1'b0, a} + b;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: expected terms come from a plain Fibonacci list model.
module tb_fib_seq_gen;
  localparam int W = 8;
`ifdef FIB_SEQ_GEN_BCD_EN
  localparam int LIM = 9;
`else
  localparam int LIM = (1 << W) - 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, clear, out_ready;
  logic [W-1:0] out_data;
  logic         out_valid, busy, done;

  fib_seq_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_done; int val; } exp_t;
  exp_t q[$];
  int   npass = 0, ntot = 0, acc_cnt = 0, exp_terms = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: every Fibonacci number not above the limit, in order, then one done pulse.
  task automatic push_expected();
    int x = 0, y = 1, t;
    exp_terms = 0;
    while (x <= LIM) begin
      q.push_back('{is_done: 1'b0, val: x});
      exp_terms++;
      t = x + y; x = y; y = t;
    end
    q.push_back('{is_done: 1'b1, val: 0});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: samples mid-cycle, pops on every accept and every done pulse.
  bit           hold = 0;
  logic [W-1:0] hold_data;
  exp_t         e;
  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (q.size() == 0) chk("unexpected_term", out_data, -1);
        else begin
          e = q.pop_front();
          if (e.is_done) chk("term_where_done_expected", out_data, -1);
          else chk("term", out_data, e.val);
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_order", e.is_done, 1);
        end
      end
      hold = out_valid && !out_ready && !clear;
      hold_data = out_data;
    end
  end

  task automatic run_seq(input bit rnd, input bit poke, output int k);
    bit seen = 0;
    out_ready = 1'b1;
    start = 1'b1;
    push_expected();
    step();
    start = 1'b0;
    chk("latency_valid", out_valid, 1);
    chk("latency_data", out_data, 0);
    k = 0;
    while (!seen && k < 600) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
      k++;
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    start = poke;
    step();
    start = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  int k, base, n;
  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // full-rate run: one term per cycle, done right after the last term
    run_seq(1'b0, 1'b0, k);
    chk("term_cycles", k, exp_terms);

    // backpressure with stray starts during RUN and DONE
    repeat (3) run_seq(1'b1, 1'b1, k);

    // clear after the fifth accepted term
    base = acc_cnt;
    out_ready = 1'b1;
    start = 1'b1;
    push_expected();
    step();
    start = 1'b0;
    n = 0;
    while (acc_cnt - base < 5 && n < 100) begin step(); n++; end
    chk("clear_at_term5", acc_cnt - base, 5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.delete();
    chk("clear_valid", out_valid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_done", done, 0);
    repeat (3) begin step(); chk("no_done_after_clear", done, 0); end
    run_seq(1'b1, 1'b0, k);

    // start together with clear in IDLE is ignored
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    chk("start_clear_valid", out_valid, 0);
    step();
    chk("start_clear_busy", busy, 0);

    // asynchronous reset mid-RUN
    out_ready = 1'b1;
    start = 1'b1;
    push_expected();
    step();
    start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_data", out_data, 0);
    q.delete();
    step();
    rst_n = 1'b1;
    step();
    run_seq(1'b1, 1'b0, k);

    repeat (4) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
